// File: rtl/risc_pkg.sv
// ISA constants shared by the fetch and control units.
// Holds opcode encodings and a small opcode decode helper.
package risc_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  function automatic logic is_halt(input logic [3:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO with flush; head is combinational, push/pop take effect at the edge.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module fetch_buf #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [W-1:0] head_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    rd_d    = rd_q ^ do_pop;
    wr_d    = wr_q ^ do_push;
    cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Flush shares the reset path so it overrides a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_q];
  assign full_o     = (cnt_q == 2'd2);
  assign empty_o    = (cnt_q == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing into a 2-deep {instr, pc} buffer, first valid 2 cycles after reset.
// Requests are throttled so buffered + in-flight never exceeds 2; stalls hold the head.
module fetch_unit
  import risc_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  localparam int ENT_W = INSTR_W + ADDR_W;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;

  logic              buf_full, buf_empty;
  logic [ENT_W-1:0]  buf_head;
  logic              pop, push, push_halt;
  logic [2:0]        occ;

  fetch_buf #(.W(ENT_W)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i ({imem_rdata, infl_addr_q}),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .head_dat_o (buf_head),
    .full_o     (buf_full),
    .empty_o    (buf_empty)
  );

  assign if_valid  = !buf_empty && !rst;
  assign if_instr  = buf_head[ENT_W-1 -: INSTR_W];
  assign if_pc     = buf_head[ADDR_W-1:0];
  assign halted    = (state_q == ST_HALT) && buf_empty && !rst;
  assign imem_addr = pc_q;

  always_comb begin
    pop       = if_valid && if_ready;
    // Responses returning while halted belong to requests issued before the HALT and are dropped.
    push      = infl_q && (state_q == ST_FETCH) && !redirect_valid && !rst;
    push_halt = push && is_halt(imem_rdata[INSTR_W-1 -: 4]);
    occ       = (buf_full ? 3'd2 : (buf_empty ? 3'd0 : 3'd1))
              + {2'b00, infl_q} - {2'b00, pop};
    imem_en   = !rst && !redirect_valid && (state_q == ST_FETCH)
              && !push_halt && (occ < 3'd2);

    state_d     = state_q;
    pc_d        = pc_q;
    infl_d      = imem_en;
    infl_addr_d = infl_addr_q;
    if (redirect_valid) begin
      state_d = ST_FETCH;
      pc_d    = redirect_pc;
      infl_d  = 1'b0;
    end else begin
      if (push_halt) state_d = ST_HALT;
      if (imem_en) begin
        pc_d        = pc_q + 1'b1;
        infl_addr_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle tables, directed corner sequences, and a random run against a stream model.
module tb_fetch_unit;
  import risc_pkg::*;

  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          if_valid;
  logic          if_ready;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halted;

  logic [IW-1:0] mem [256];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  typedef struct {
    logic          rst;
    logic          rdy;
    logic          vld;
    logic [AW-1:0] pc;
    logic          en;
    logic [AW-1:0] addr;
    logic          hlt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rdy, input logic vld,
                              input logic [AW-1:0] pc, input logic en,
                              input logic [AW-1:0] addr, input logic hlt);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.vld = vld; v.pc = pc; v.en = en; v.addr = addr; v.hlt = hlt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [AW-1:0] rpc);
    @(negedge clk);
    rst = r; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic fill_nohalt();
    logic [IW-1:0] w;
    for (int i = 0; i < 256; i++) begin
      w = IW'($urandom);
      if (w[IW-1 -: 4] == OP_HALT) w[IW-1 -: 4] = OP_ADD;
      mem[i] = w;
    end
  endtask

  // With if_ready high, expect n deliveries with consecutive PCs starting at 'first'.
  task automatic run_expect(input string tag, input logic [AW-1:0] first, input int n);
    logic [AW-1:0] e;
    int got;
    int budget;
    e = first; got = 0; budget = n + 6;
    while (got < n && budget > 0) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      budget--;
      if (if_valid) begin
        chk({tag, " pc"}, 32'(if_pc), 32'(e));
        chk({tag, " instr"}, 32'(if_instr), 32'(mem[e]));
        e++;
        got++;
      end
    end
    if (got < n) chk({tag, " timeout"}, got, n);
  endtask

  initial begin
    vec_t v;
    logic          rdy, rv;
    logic [AW-1:0] rpc, exp_pc, issue_pc;
    int            outstanding, transfers, budget;

    rst = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    fill_nohalt();
    mem[0] = 16'h0012; mem[1] = 16'h1034; mem[2] = 16'h4056; mem[3] = 16'hF000;
    do_reset();

    // Straight run into HALT with if_ready high.
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 8'h01, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 1, 8'h02, 0));
    vecs.push_back(mk(0, 1, 1, 8'h01, 1, 8'h03, 0));
    vecs.push_back(mk(0, 1, 1, 8'h02, 0, 8'h04, 0));
    vecs.push_back(mk(0, 1, 1, 8'h03, 0, 8'h04, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h04, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h04, 1));
    // Five-cycle stall from the first valid, then release.
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h01, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h02, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 1, 8'h02, 0));
    vecs.push_back(mk(0, 1, 1, 8'h01, 1, 8'h03, 0));
    vecs.push_back(mk(0, 1, 1, 8'h02, 0, 8'h04, 0));
    vecs.push_back(mk(0, 1, 1, 8'h03, 0, 8'h04, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h04, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst, v.rdy, 1'b0, '0);
      chk($sformatf("vec%0d if_valid", i), 32'(if_valid), 32'(v.vld));
      if (v.vld) begin
        chk($sformatf("vec%0d if_pc", i), 32'(if_pc), 32'(v.pc));
        chk($sformatf("vec%0d if_instr", i), 32'(if_instr), 32'(mem[v.pc]));
      end
      chk($sformatf("vec%0d imem_en", i), 32'(imem_en), 32'(v.en));
      if (!v.rst) chk($sformatf("vec%0d imem_addr", i), 32'(imem_addr), 32'(v.addr));
      chk($sformatf("vec%0d halted", i), 32'(halted), 32'(v.hlt));
    end

    // Redirect while the buffer is full.
    do_reset();
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 8'h40);
    chk("redir_full en", 32'(imem_en), 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    chk("redir_full stale valid", 32'(if_valid), 0);
    chk("redir_full addr", 32'(imem_addr), 32'h40);
    run_expect("redir_full", 8'h40, 3);

    // Redirect coinciding with a transfer and an in-flight response.
    do_reset();
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 8'h40);
    chk("redir_xfer pc", 32'(if_pc), 32'h01);
    chk("redir_xfer en", 32'(imem_en), 0);
    run_expect("redir_infl", 8'h40, 3);

    // PC wrap.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 8'hFE);
    chk("wrap redirect en", 32'(imem_en), 0);
    run_expect("wrap", 8'hFE, 4);

    // Leave HALT through a redirect.
    do_reset();
    run_expect("pre_halt", 8'h00, 4);
    budget = 6;
    while (!halted && budget > 0) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      budget--;
    end
    chk("halt reached", 32'(halted), 1);
    chk("halt no fetch", 32'(imem_en), 0);
    drive(1'b0, 1'b1, 1'b1, 8'h10);
    chk("halt redirect en", 32'(imem_en), 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    chk("halt exit halted", 32'(halted), 0);
    chk("halt exit en", 32'(imem_en), 1);
    chk("halt exit addr", 32'(imem_addr), 32'h10);
    run_expect("resume", 8'h10, 3);

    // Reset mid-stream with a request in flight.
    do_reset();
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, '0);
    chk("midrst en", 32'(imem_en), 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    chk("midrst valid", 32'(if_valid), 0);
    run_expect("post_rst", 8'h00, 2);

    // Random stalls and redirects against a sequential-stream model.
    fill_nohalt();
    do_reset();
    exp_pc = '0; issue_pc = '0; outstanding = 0; transfers = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(3) != 0);
      rv  = ($urandom_range(49) == 0);
      rpc = AW'($urandom);
      drive(1'b0, rdy, rv, rpc);
      if (rv) chk("rnd en during redirect", 32'(imem_en), 0);
      if (if_valid && rdy) begin
        chk("rnd pc", 32'(if_pc), 32'(exp_pc));
        chk("rnd instr", 32'(if_instr), 32'(mem[exp_pc]));
        exp_pc++;
        outstanding--;
        transfers++;
      end
      if (imem_en) begin
        chk("rnd issue addr", 32'(imem_addr), 32'(issue_pc));
        issue_pc++;
        outstanding++;
      end
      chk("rnd outstanding<=2", 32'(outstanding <= 2), 1);
      if (rv) begin
        exp_pc = rpc; issue_pc = rpc; outstanding = 0;
      end
    end
    chk("rnd throughput", 32'(transfers >= 1500), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, PC and instruction memory address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width; opcode is bits [INSTR_W-1 -: 4].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_en  output  1  read request to synchronous instruction memory.
REQ-006 SHALL have port imem_addr  output  ADDR_W  read address, equal to the current PC.
REQ-007 SHALL have port imem_rdata  input  INSTR_W  read data, valid exactly one cycle after imem_en.
REQ-008 SHALL have port if_valid  output  1  buffered instruction available to decode and control.
REQ-009 SHALL have port if_ready  input  1  decode and control accepts the instruction.
REQ-010 SHALL have port if_instr  output  INSTR_W  instruction at the buffer head.
REQ-011 SHALL have port if_pc  output  ADDR_W  address of if_instr.
REQ-012 SHALL have port redirect_valid  input  1  PC override request.
REQ-013 SHALL have port redirect_pc  input  ADDR_W  new PC.
REQ-014 SHALL have port halted  output  1  HALT state reached and buffer drained.

Function
REQ-015 SHALL contain a two-entry FIFO of {instr, pc} pairs; if_valid = not empty; if_instr and if_pc come combinationally from the head.
REQ-016 SHALL complete a transfer on a cycle with if_valid and if_ready both high; the head is popped at that edge.
REQ-017 SHALL have FSM states FETCH and HALT; reset state is FETCH.
REQ-018 SHALL, in FETCH, assert imem_en when FIFO occupancy + in-flight requests (0 or 1) < 2, after accounting for a pop in the same cycle; PC increments by 1 on each issued request.
REQ-019 SHALL wrap PC modulo 2^ADDR_W (8'hFF -> 8'h00), with no stall or flag.
REQ-020 SHALL push {imem_rdata, issued address} one cycle after each issued request; FIFO capacity rules (REQ-018) guarantee it never overflows.
REQ-021 SHALL move FETCH -> HALT when a pushed instruction has opcode 4'hF; that HALT instruction is still delivered; imem_en is held low from that cycle.
REQ-022 SHALL discard, in HALT, any response returning for a request issued before the HALT was pushed; PC stays at its post-increment value.
REQ-023 SHALL assert halted when in HALT with the FIFO empty.
REQ-024 SHALL, on redirect_valid, at that edge: flush the FIFO, mark any in-flight response as discarded, load PC <= redirect_pc, enter FETCH (also exits HALT); no imem_en during the redirect cycle.
REQ-025 SHALL, on redirect coinciding with a transfer, let the transfer complete; the redirect flush takes priority over the push that cycle.
REQ-026 SHALL reach a sustained throughput of one instruction per cycle with if_ready held high; the first if_valid appears 2 cycles after reset deasserts.

Reset
REQ-027 SHALL, while rst is high: PC=0, FIFO empty, no in-flight request, state FETCH, imem_en=0, if_valid=0, halted=0.
REQ-028 SHALL treat rst asserted mid-operation as a full abort: the pending response is discarded and buffered instructions are lost.
REQ-029 SHALL have rst take priority over redirect_valid.

Structure
REQ-030 SHALL take OP_HALT (4'hF), and the ADD/SUB/LOAD/STORE opcode constants shared with the control unit, from a shared package named risc_pkg.
REQ-031 SHALL implement the two-entry FIFO as sub-module fetch_buf (parameterised by width; push/pop/flush, full/empty).

Verification
REQ-032 SHALL verify: reset, memory words 0x0012,0x1034,0x4056,0xF000 at 0..3, if_ready=1 -> if_pc 0,1,2,3 on consecutive cycles from cycle 2; halted=1 after the 0xF000 transfer; no imem_en after address 4.
REQ-033 SHALL verify: if_ready=0 for 5 cycles from the first valid -> at most 2 requests outstanding, if_pc holds 0, no instruction lost or duplicated after release.
REQ-034 SHALL verify: redirect_valid with redirect_pc=8'h40 while the FIFO is full -> next delivered if_pc=8'h40; the older entries and the in-flight response never appear.
REQ-035 SHALL verify: start by redirect to 8'hFE over non-HALT words -> if_pc sequence FE,FF,00,01.
REQ-036 SHALL verify: in HALT with halted=1, redirect to 8'h10 -> halted drops next cycle and fetching resumes at 8'h10.
REQ-037 SHALL verify: rst asserted for one cycle mid-stream with a request in flight -> if_valid=0 the following cycle and the next delivered if_pc=0.
